// File: rtl/rom_arb_pkg.sv
// rtl/rom_arb_pkg.sv - shared defaults and requester indices for the ROM arbiter
package rom_arb_pkg;

  localparam int N_REQ_DEF  = 3;
  localparam int AW_DEF     = 19;
  localparam int DW_DEF     = 4;
  localparam int RD_LAT_DEF = 1;

  typedef enum logic [1:0] {
    REQ_BG   = 2'd0,
    REQ_BALL = 2'd1,
    REQ_WALL = 2'd2
  } req_idx_e;

endpackage

// File: rtl/rom_arbiter_if.sv
// rtl/rom_arbiter_if.sv - requester/ROM signal bundle between the arbiter and its clients
interface rom_arbiter_if
  import rom_arb_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int AW    = AW_DEF,
  parameter int DW    = DW_DEF
) ();

  logic                   hold_off;
  logic [N_REQ-1:0]       req;
  logic [N_REQ*AW-1:0]    addr;
  logic [N_REQ-1:0]       gnt;
  logic [AW-1:0]          rom_addr;
  logic [DW-1:0]          rom_q;
  logic [DW-1:0]          rdata;
  logic [N_REQ-1:0]       rvalid;

  modport slave (
    input  hold_off, req, addr, rom_q,
    output gnt, rom_addr, rdata, rvalid
  );

  modport master (
    output hold_off, req, addr, rom_q,
    input  gnt, rom_addr, rdata, rvalid
  );

endinterface

// File: rtl/rr_arbiter_core.sv
// rtl/rr_arbiter_core.sv - combinational round-robin pick with its rotating priority pointer
module rr_arbiter_core
  import rom_arb_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             hold_off_i,
  input  logic [N_REQ-1:0] req_i,
  output logic [N_REQ-1:0] gnt_o
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [PW-1:0] ptr_q, ptr_d;
  logic          found;

  // Search upward from ptr with explicit wrap so indices >= N_REQ never appear.
  always_comb begin
    gnt_o = '0;
    ptr_d = ptr_q;
    found = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      int            idx;
      logic [PW-1:0] sel;
      idx = int'(ptr_q) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      sel = PW'(idx);
      if (!found && !hold_off_i && !rst_i && req_i[sel]) begin
        found      = 1'b1;
        gnt_o[sel] = 1'b1;
        ptr_d      = (idx + 1 == N_REQ) ? '0 : PW'(idx + 1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

endmodule

// File: rtl/rom_arbiter.sv
// rtl/rom_arbiter.sv - shares one single-port ROM among N_REQ requesters with tagged read-back
module rom_arbiter
  import rom_arb_pkg::*;
#(
  parameter int N_REQ  = N_REQ_DEF,
  parameter int AW     = AW_DEF,
  parameter int DW     = DW_DEF,
  parameter int RD_LAT = RD_LAT_DEF
) (
  input  logic          vga_clk,
  input  logic          Reset,
  rom_arbiter_if.slave  bus
);

  logic [N_REQ-1:0] gnt;
  logic [N_REQ-1:0] accept;
  logic [AW-1:0]    rom_addr_q, rom_addr_d;
  logic [N_REQ-1:0] tag_q [RD_LAT+1];

  rr_arbiter_core #(.N_REQ(N_REQ)) u_core (
    .clk_i      (vga_clk),
    .rst_i      (Reset),
    .hold_off_i (bus.hold_off),
    .req_i      (bus.req),
    .gnt_o      (gnt)
  );

  assign accept = gnt & bus.req;

  always_comb begin
    rom_addr_d = rom_addr_q;
    for (int i = 0; i < N_REQ; i++) begin
      if (accept[i]) rom_addr_d = bus.addr[i*AW +: AW];
    end
  end

  // Stage 0 lines up with rom_addr; stage RD_LAT lines up with rom_q.
  always_ff @(posedge vga_clk) begin
    if (Reset) begin
      rom_addr_q <= '0;
      for (int s = 0; s <= RD_LAT; s++) tag_q[s] <= '0;
    end else begin
      rom_addr_q <= rom_addr_d;
      tag_q[0]   <= accept;
      for (int s = 1; s <= RD_LAT; s++) tag_q[s] <= tag_q[s-1];
    end
  end

  assign bus.gnt      = gnt;
  assign bus.rom_addr = rom_addr_q;
  assign bus.rdata    = bus.rom_q;
  assign bus.rvalid   = tag_q[RD_LAT];

endmodule

// File: tb/tb_rom_arbiter.sv
// tb/tb_rom_arbiter.sv - directed vector table plus randomized scoreboard bench for rom_arbiter
module tb_rom_arbiter;
  import rom_arb_pkg::*;

  localparam int N  = 3;
  localparam int AW = 19;
  localparam int DW = 4;

  logic vga_clk = 1'b0;
  logic Reset;

  always #5 vga_clk = ~vga_clk;

  rom_arbiter_if #(.N_REQ(N), .AW(AW), .DW(DW)) bus ();

  rom_arbiter #(.N_REQ(N), .AW(AW), .DW(DW), .RD_LAT(1)) dut (
    .vga_clk (vga_clk),
    .Reset   (Reset),
    .bus     (bus)
  );

  function automatic logic [DW-1:0] rom_f(input logic [AW-1:0] a);
    return a[3:0] ^ a[7:4] ^ a[11:8] ^ a[15:12] ^ {1'b0, a[18:16]};
  endfunction

  // ROM with one cycle of read latency
  always @(posedge vga_clk) bus.rom_q <= rom_f(bus.rom_addr);

  typedef struct {
    logic       rst;
    logic       hold;
    logic [2:0] req;
    int         a0, a1, a2;
    logic [2:0] gnt;
    int         ra;
  } vec_t;

  typedef struct {
    int          due;
    logic [2:0]  oh;
    logic [DW-1:0] data;
  } sb_t;

  vec_t       tbl [28];
  sb_t        sbq [$];
  int         errors = 0;
  int         checks = 0;
  int         cyc = 0;
  int         ptr_m = 0;
  logic [AW-1:0] ra_m = '0;
  bit         ra_known = 0;
  int         wt [N];
  logic [2:0] last_acc = '0;

  function automatic vec_t mk(logic rst, logic hold, logic [2:0] req, int a0, int a1, int a2,
                              logic [2:0] gnt, int ra);
    vec_t v;
    v.rst = rst; v.hold = hold; v.req = req;
    v.a0 = a0; v.a1 = a1; v.a2 = a2; v.gnt = gnt; v.ra = ra;
    return v;
  endfunction

  function automatic logic [2:0] pick(input logic [2:0] r, input int p);
    for (int k = 0; k < N; k++) begin
      int j;
      j = (p + k) % N;
      if (r[j]) return 3'(1 << j);
    end
    return 3'b000;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic step(input logic rst, input logic hold, input logic [2:0] r,
                      input int a0, input int a1, input int a2,
                      input bit use_tbl, input logic [2:0] tgnt, input int tra);
    logic [2:0]    exp_g;
    logic [2:0]    exp_rv;
    logic [AW-1:0] sl [N];
    sl[0] = AW'(a0); sl[1] = AW'(a1); sl[2] = AW'(a2);
    Reset        = rst;
    bus.hold_off = hold;
    bus.req      = r;
    bus.addr     = {sl[2], sl[1], sl[0]};
    @(negedge vga_clk);
    exp_g = (rst || hold) ? 3'b000 : pick(r, ptr_m);
    chk("gnt", 32'(bus.gnt), 32'(exp_g));
    chk("gnt_onehot0", 32'($onehot0(bus.gnt)), 32'd1);
    if (use_tbl) begin
      chk("gnt_vec", 32'(bus.gnt), 32'(tgnt));
      if (tra >= 0) chk("rom_addr_vec", 32'(bus.rom_addr), tra);
    end
    if (ra_known) chk("rom_addr", 32'(bus.rom_addr), 32'(ra_m));
    exp_rv = 3'b000;
    if (sbq.size() > 0 && sbq[0].due == cyc) exp_rv = sbq[0].oh;
    chk("rvalid", 32'(bus.rvalid), 32'(exp_rv));
    if (exp_rv != 3'b000) begin
      chk("rdata", 32'(bus.rdata), 32'(sbq[0].data));
      void'(sbq.pop_front());
    end
    for (int i = 0; i < N; i++) begin
      if (rst || !r[i] || bus.gnt[i]) wt[i] = 0;
      else if (!hold) begin
        wt[i]++;
        if (wt[i] > N - 1) chk("max_wait", 32'(wt[i]), 32'(N - 1));
      end
    end
    last_acc = exp_g;
    if (rst) begin
      ptr_m = 0; ra_m = '0; ra_known = 1;
      sbq.delete();
    end else if (exp_g != 3'b000) begin
      for (int i = 0; i < N; i++) begin
        if (exp_g[i]) begin
          sbq.push_back('{due: cyc + 2, oh: exp_g, data: rom_f(sl[i])});
          ra_m  = sl[i];
          ptr_m = (i + 1) % N;
        end
      end
    end
    cyc++;
    @(posedge vga_clk);
    #1;
  endtask

  initial begin
    logic [2:0] rq;
    int         ad [N];
    logic       hd, rs;
    for (int i = 0; i < N; i++) wt[i] = 0;
    Reset = 1'b1; bus.hold_off = 1'b0; bus.req = '0; bus.addr = '0;

    tbl[0]  = mk(1, 0, 3'b000, 100, 200, 300, 3'b000, -1);
    tbl[1]  = mk(1, 0, 3'b000, 100, 200, 300, 3'b000, 0);
    tbl[2]  = mk(0, 0, 3'b111, 100, 200, 300, 3'b001, 0);
    tbl[3]  = mk(0, 0, 3'b111, 100, 200, 300, 3'b010, 100);
    tbl[4]  = mk(0, 0, 3'b111, 100, 200, 300, 3'b100, 200);
    tbl[5]  = mk(0, 0, 3'b111, 100, 200, 300, 3'b001, 300);
    tbl[6]  = mk(0, 0, 3'b111, 100, 200, 300, 3'b010, 100);
    tbl[7]  = mk(0, 0, 3'b111, 100, 200, 300, 3'b100, 200);
    tbl[8]  = mk(0, 0, 3'b010, 100, 5,   300, 3'b010, 300);
    tbl[9]  = mk(0, 0, 3'b010, 100, 6,   300, 3'b010, 5);
    tbl[10] = mk(0, 0, 3'b010, 100, 7,   300, 3'b010, 6);
    tbl[11] = mk(0, 0, 3'b010, 100, 8,   300, 3'b010, 7);
    tbl[12] = mk(0, 0, 3'b000, 100, 200, 300, 3'b000, 8);
    tbl[13] = mk(0, 0, 3'b000, 100, 200, 300, 3'b000, 8);
    tbl[14] = mk(0, 0, 3'b100, 100, 200, 300, 3'b100, 8);
    tbl[15] = mk(0, 0, 3'b101, 100, 200, 300, 3'b001, 300);
    tbl[16] = mk(0, 0, 3'b101, 100, 200, 300, 3'b100, 100);
    tbl[17] = mk(0, 0, 3'b111, 100, 200, 300, 3'b001, 300);
    tbl[18] = mk(0, 1, 3'b111, 100, 200, 300, 3'b000, 100);
    tbl[19] = mk(0, 1, 3'b111, 100, 200, 300, 3'b000, 100);
    tbl[20] = mk(0, 1, 3'b111, 100, 200, 300, 3'b000, 100);
    tbl[21] = mk(0, 0, 3'b111, 100, 200, 300, 3'b010, 100);
    tbl[22] = mk(0, 0, 3'b000, 100, 200, 300, 3'b000, 200);
    tbl[23] = mk(0, 0, 3'b001, 100, 200, 300, 3'b001, 200);
    tbl[24] = mk(1, 0, 3'b001, 100, 200, 300, 3'b000, 100);
    tbl[25] = mk(0, 0, 3'b111, 100, 200, 300, 3'b001, 0);
    tbl[26] = mk(0, 0, 3'b000, 100, 200, 300, 3'b000, 100);
    tbl[27] = mk(0, 0, 3'b000, 100, 200, 300, 3'b000, 100);

    for (int v = 0; v < 28; v++)
      step(tbl[v].rst, tbl[v].hold, tbl[v].req, tbl[v].a0, tbl[v].a1, tbl[v].a2,
           1'b1, tbl[v].gnt, tbl[v].ra);

    // Requesters hold req and addr until accepted, then pick a fresh request.
    rq = '0;
    for (int i = 0; i < N; i++) ad[i] = 0;
    for (int c = 0; c < 10000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!rq[i] || last_acc[i]) begin
          rq[i] = ($urandom_range(0, 2) != 0);
          ad[i] = int'($urandom_range(0, 307199));
        end
      end
      hd = ($urandom_range(0, 9) == 0);
      rs = ($urandom_range(0, 499) == 0);
      step(rs, hd, rq, ad[0], ad[1], ad[2], 1'b0, 3'b000, -1);
    end

    for (int c = 0; c < 4; c++) step(1'b0, 1'b0, 3'b000, 0, 0, 0, 1'b0, 3'b000, -1);
    chk("scoreboard_drained", 32'(sbq.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rom_arbiter.md
ROM_ARBITER -- requirements
Module: rom_arbiter

Interface
- REQ-001: Parameter N_REQ, default 3: number of requesters; index 0 = background, 1 = ball sprite, 2 = wall sprite.
- REQ-002: Parameter AW, default 19: ROM address width, covering 640x480 = 307200 words.
- REQ-003: Parameter DW, default 4: ROM word width, a palette index.
- REQ-004: Parameter RD_LAT, default 1: ROM cycles from rom_addr to valid rom_q.
- REQ-005: vga_clk  input  1  sole clock; all state updates on its rising edge.
- REQ-006: Reset  input  1  synchronous, active-high reset.
- REQ-007: hold_off  input  1  while high, no grants are issued.
- REQ-008: req  input  N_REQ  per-requester read request; held with its address until granted.
- REQ-009: addr  input  N_REQ*AW  per-requester read address; slice i belongs to requester i.
- REQ-010: gnt  output  N_REQ  one-hot grant; combinational; at most one bit high per cycle.
- REQ-011: rom_addr  output  AW  registered address to the single-port ROM.
- REQ-012: rom_q  input  DW  ROM read data.
- REQ-013: rdata  output  DW  rom_q passed through, shared by all requesters.
- REQ-014: rvalid  output  N_REQ  registered one-hot flag: rdata belongs to requester i this cycle.

Function
- REQ-015: A request is accepted in cycle N when req[i]=1 and gnt[i]=1 in that cycle; the requester may change req and addr in N+1.
- REQ-016: gnt shall be all-zero whenever hold_off=1 or Reset=1.
- REQ-017: Arbitration is round-robin over a pointer ptr (range 0..N_REQ-1); the winner is the first asserted req at or after ptr, searching upward with wrap-around.
- REQ-018: After a grant to requester i, ptr becomes (i+1) mod N_REQ at the next edge; with no grant, ptr is unchanged.
- REQ-019: On an accept in cycle N, rom_addr takes addr slice i at edge N+1; without an accept, rom_addr holds its value.
- REQ-020: For an accept in cycle N, rvalid[i]=1 in cycle N+1+RD_LAT, aligned with the matching rom_q; rdata = rom_q in every cycle.
- REQ-021: Tags travel in a shift register of depth 1+RD_LAT, so one accept per cycle is sustained with no bubbles.
- REQ-022: A single requester holding req continuously is granted every cycle; throughput is 1 read per cycle.
- REQ-023: When all requesters hold req continuously, grants rotate 0,1,2,0,... from reset; no requester waits more than N_REQ-1 cycles.
- REQ-024: Raising hold_off does not cancel reads already accepted; their rvalid still appears on schedule.
- REQ-025: Requester indices at or above N_REQ do not exist; the wrap-around uses mod N_REQ exactly.

Reset
- REQ-026: When Reset=1 at an edge: ptr=0, rom_addr=0, every tag pipeline stage cleared, and rvalid=0 from the next cycle on.
- REQ-027: Reads in flight when reset is asserted are dropped, with no rvalid afterwards; the first grant after reset follows REQ-017 with ptr=0.

Structure
- REQ-028: Package rom_arb_pkg holds the N_REQ default, the AW, DW and RD_LAT defaults, and the requester index enum (REQ_BG=0, REQ_BALL=1, REQ_WALL=2).
- REQ-029: One sub-module, rr_arbiter_core, contains the combinational round-robin pick and the ptr register; rom_arbiter adds the address register and the tag pipeline.

Verification
- REQ-030: After reset, req=3'b111 held for 6 cycles with addr = {300, 200, 100} for requesters {2, 1, 0} -> gnt 001,010,100,001,010,100; rom_addr 100,200,300 repeating; rvalid matches gnt delayed by 2 cycles (RD_LAT=1).
- REQ-031: Only req[1] high for 4 cycles, addr=5,6,7,8 -> gnt[1] every cycle; rvalid[1] for 4 consecutive cycles; rdata equals the ROM contents at 5..8 in order.
- REQ-032: Grant to requester 2, then req=3'b101 -> requester 0 is granted next (ptr wrapped to 0), then requester 2.
- REQ-033: hold_off=1 for 3 cycles with req=3'b111 -> gnt=0 and rom_addr unchanged; a read accepted in the cycle before hold_off still returns rvalid on schedule.
- REQ-034: Reset asserted 1 cycle after an accept -> no rvalid for that read; next grant goes to requester 0 if req[0]=1.
- REQ-035: Random req/addr for 10k cycles -> gnt is always one-hot or zero; every accept returns exactly one rvalid with the correct ROM data; no requester waits more than 2 cycles.
